amb_cok_dongulu: RTL and testbench

Parametrised, registered successor to the core's integer ALU: XLEN-wide datapath, valid/ready handshake on both sides, tag passthrough, Zbb-style MIN/MAX/MINU/MAXU, and an iterative shifter whose per-cycle shift step is configurable. It sits in the execute stage and replaces the purely combinational unit where timing or area demands a registered result. A flush input lets the pipeline kill an in-flight operation.

---
 rtl/amb_cok_dongulu_pkg.sv | 44 ++++
 rtl/amb_cok_dongulu_kaydirma_adimi.sv | 23 ++
 rtl/amb_cok_dongulu.sv | 173 +++++++++++++++++
 tb/tb_amb_cok_dongulu.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amb_cok_dongulu_pkg.sv
// Shared definitions for the registered integer ALU: operation codes, FSM states
// and the shift-type payload latched across iterative shift cycles.
package amb_cok_dongulu_pkg;

    typedef enum logic [3:0] {
        AMB_TOPLAMA = 4'h0,
        AMB_CIKARMA = 4'h1,
        AMB_XOR     = 4'h2,
        AMB_OR      = 4'h3,
        AMB_AND     = 4'h4,
        AMB_SLT     = 4'h5,
        AMB_SLTU    = 4'h6,
        AMB_GECIR   = 4'h7,
        AMB_SLL     = 4'h8,
        AMB_SRL     = 4'h9,
        AMB_SRA     = 4'hA,
        AMB_MIN     = 4'hB,
        AMB_MAX     = 4'hC,
        AMB_MINU    = 4'hD,
        AMB_MAXU    = 4'hE
    } amb_islem_e;

    typedef enum logic {
        BOSTA  = 1'b0,
        KAYDIR = 1'b1
    } amb_durum_e;

    typedef struct packed {
        logic sola;
        logic aritmetik;
    } kaydirma_tur_t;

    function automatic logic kaydirma_mi(input logic [3:0] kontrol);
        return (kontrol == AMB_SLL) || (kontrol == AMB_SRL) || (kontrol == AMB_SRA);
    endfunction

    function automatic kaydirma_tur_t kaydirma_turu(input logic [3:0] kontrol);
        kaydirma_tur_t tur;
        tur.sola      = (kontrol == AMB_SLL);
        tur.aritmetik = (kontrol == AMB_SRA);
        return tur;
    endfunction

endpackage

// File: rtl/amb_cok_dongulu_kaydirma_adimi.sv
// One combinational shift step; the caller bounds the amount to the per-cycle step.
module amb_kaydirma_adimi #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] deger,
    input  logic [SHW-1:0]  miktar,
    input  logic            sola,
    input  logic            aritmetik,
    output logic [XLEN-1:0] sonuc
);

    always_comb begin
        if (sola) begin
            sonuc = deger << miktar;
        end else if (aritmetik) begin
            sonuc = XLEN'($signed(deger) >>> miktar);
        end else begin
            sonuc = deger >> miktar;
        end
    end

endmodule

// File: rtl/amb_cok_dongulu.sv
// Registered integer ALU with valid/ready on both sides, tag passthrough and an
// iterative shifter that moves at most KAYDIRMA_ADIM bits per cycle.
module amb_cok_dongulu
    import amb_cok_dongulu_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned KAYDIRMA_ADIM = XLEN,
    parameter int unsigned ETIKET_BIT    = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  gecerli_i,
    output logic                  hazir_o,
    input  logic [3:0]            kontrol_i,
    input  logic [XLEN-1:0]       deger1_i,
    input  logic [XLEN-1:0]       deger2_i,
    input  logic [ETIKET_BIT-1:0] etiket_i,
    input  logic                  iptal_i,
    output logic                  gecerli_o,
    input  logic                  hazir_i,
    output logic [XLEN-1:0]       sonuc_o,
    output logic [ETIKET_BIT-1:0] etiket_o
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned AW  = SHW + 1;
    localparam logic [AW-1:0] ADIM = AW'(KAYDIRMA_ADIM);

    amb_durum_e            durum_q, durum_d;
    logic [XLEN-1:0]       calisma_q, calisma_d;
    logic [SHW-1:0]        kalan_q, kalan_d;
    kaydirma_tur_t         tur_q, tur_d;
    logic [ETIKET_BIT-1:0] etiket_is_q, etiket_is_d;
    logic                  gecerli_d;
    logic [XLEN-1:0]       sonuc_d;
    logic [ETIKET_BIT-1:0] etiket_d;

    logic                  cikis_bos;
    logic                  kabul;
    logic [XLEN-1:0]       alu_sonuc;
    logic [XLEN-1:0]       kd_deger;
    logic [AW-1:0]         kd_ham;
    logic [AW-1:0]         kd_adim;
    logic [AW-1:0]         kd_kalan;
    logic                  son_adim;
    kaydirma_tur_t         kd_tur;
    logic [XLEN-1:0]       kd_sonuc;
    logic                  slt, sltu;

    assign cikis_bos = !gecerli_o || hazir_i;
    assign hazir_o   = (durum_q == BOSTA) && cikis_bos;
    assign kabul     = gecerli_i && hazir_o && !iptal_i;

    // Shifter operand select: fresh operands when idle, working register while iterating.
    always_comb begin
        kd_deger = deger1_i;
        kd_ham   = {1'b0, deger2_i[SHW-1:0]};
        kd_tur   = kaydirma_turu(kontrol_i);
        if (durum_q == KAYDIR) begin
            kd_deger = calisma_q;
            kd_ham   = {1'b0, kalan_q};
            kd_tur   = tur_q;
        end
        kd_adim  = (kd_ham > ADIM) ? ADIM : kd_ham;
        kd_kalan = kd_ham - kd_adim;
        son_adim = (kd_ham <= ADIM);
    end

    amb_kaydirma_adimi #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_kaydirma_adimi (
        .deger     (kd_deger),
        .miktar    (SHW'(kd_adim)),
        .sola      (kd_tur.sola),
        .aritmetik (kd_tur.aritmetik),
        .sonuc     (kd_sonuc)
    );

    assign slt  = $signed(deger1_i) < $signed(deger2_i);
    assign sltu = deger1_i < deger2_i;

    // Single-cycle operations; unknown codes produce zero.
    always_comb begin
        alu_sonuc = '0;
        case (kontrol_i)
            AMB_TOPLAMA: alu_sonuc = deger1_i + deger2_i;
            AMB_CIKARMA: alu_sonuc = deger1_i - deger2_i;
            AMB_XOR:     alu_sonuc = deger1_i ^ deger2_i;
            AMB_OR:      alu_sonuc = deger1_i | deger2_i;
            AMB_AND:     alu_sonuc = deger1_i & deger2_i;
            AMB_SLT:     alu_sonuc = {{(XLEN-1){1'b0}}, slt};
            AMB_SLTU:    alu_sonuc = {{(XLEN-1){1'b0}}, sltu};
            AMB_GECIR:   alu_sonuc = deger2_i;
            AMB_MIN:     alu_sonuc = slt  ? deger1_i : deger2_i;
            AMB_MAX:     alu_sonuc = slt  ? deger2_i : deger1_i;
            AMB_MINU:    alu_sonuc = sltu ? deger1_i : deger2_i;
            AMB_MAXU:    alu_sonuc = sltu ? deger2_i : deger1_i;
            default:     alu_sonuc = '0;
        endcase
    end

    // Next-state and output-register update.
    always_comb begin
        durum_d     = durum_q;
        calisma_d   = calisma_q;
        kalan_d     = kalan_q;
        tur_d       = tur_q;
        etiket_is_d = etiket_is_q;
        gecerli_d   = gecerli_o && !hazir_i;
        sonuc_d     = sonuc_o;
        etiket_d    = etiket_o;

        if (iptal_i) begin
            gecerli_d = 1'b0;
            durum_d   = BOSTA;
            kalan_d   = '0;
        end else begin
            case (durum_q)
                BOSTA: begin
                    if (kabul) begin
                        if (kaydirma_mi(kontrol_i) && !son_adim) begin
                            calisma_d   = kd_sonuc;
                            kalan_d     = SHW'(kd_kalan);
                            tur_d       = kd_tur;
                            etiket_is_d = etiket_i;
                            durum_d     = KAYDIR;
                        end else begin
                            gecerli_d = 1'b1;
                            sonuc_d   = kaydirma_mi(kontrol_i) ? kd_sonuc : alu_sonuc;
                            etiket_d  = etiket_i;
                        end
                    end
                end
                KAYDIR: begin
                    // Once kalan reaches zero the step is a no-op, freezing the value.
                    calisma_d = kd_sonuc;
                    kalan_d   = SHW'(kd_kalan);
                    if (son_adim && cikis_bos) begin
                        gecerli_d = 1'b1;
                        sonuc_d   = kd_sonuc;
                        etiket_d  = etiket_is_q;
                        durum_d   = BOSTA;
                    end
                end
                default: durum_d = BOSTA;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q     <= BOSTA;
            calisma_q   <= '0;
            kalan_q     <= '0;
            tur_q       <= '0;
            etiket_is_q <= '0;
            gecerli_o   <= 1'b0;
            sonuc_o     <= '0;
            etiket_o    <= '0;
        end else begin
            durum_q     <= durum_d;
            calisma_q   <= calisma_d;
            kalan_q     <= kalan_d;
            tur_q       <= tur_d;
            etiket_is_q <= etiket_is_d;
            gecerli_o   <= gecerli_d;
            sonuc_o     <= sonuc_d;
            etiket_o    <= etiket_d;
        end
    end

endmodule

// File: tb/tb_amb_cok_dongulu.sv
// Bench for amb_cok_dongulu: vector table, hand sequences for stall/flush/reset,
// and randomized traffic against a cycle-count reference model.
module tb_amb_cok_dongulu;
    import amb_cok_dongulu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        gecerli_i, hazir_i, iptal_i;
    logic [3:0]  kontrol_i;
    logic [31:0] d1, d2;
    logic [4:0]  etiket_i;
    logic        hazir_o, gecerli_o;
    logic [31:0] sonuc_o;
    logic [4:0]  etiket_o;

    logic        g64, hzi64, ip64, hzo64, go64;
    logic [3:0]  k64;
    logic [63:0] a64, b64, s64;
    logic [4:0]  t64, eo64;

    int n_cmp = 0;
    int n_err = 0;

    amb_cok_dongulu #(.XLEN(32), .KAYDIRMA_ADIM(4), .ETIKET_BIT(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .gecerli_i(gecerli_i), .hazir_o(hazir_o),
        .kontrol_i(kontrol_i), .deger1_i(d1), .deger2_i(d2), .etiket_i(etiket_i),
        .iptal_i(iptal_i), .gecerli_o(gecerli_o), .hazir_i(hazir_i),
        .sonuc_o(sonuc_o), .etiket_o(etiket_o)
    );

    amb_cok_dongulu #(.XLEN(64), .KAYDIRMA_ADIM(16), .ETIKET_BIT(5)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .gecerli_i(g64), .hazir_o(hzo64),
        .kontrol_i(k64), .deger1_i(a64), .deger2_i(b64), .etiket_i(t64),
        .iptal_i(ip64), .gecerli_o(go64), .hazir_i(hzi64),
        .sonuc_o(s64), .etiket_o(eo64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        n_cmp++;
        if (gercek !== beklenen) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", ad, gercek, beklenen);
        end
    endtask

    // Reference behaviour from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            AMB_TOPLAMA: return a + b;
            AMB_CIKARMA: return a - b;
            AMB_XOR:     return a ^ b;
            AMB_OR:      return a | b;
            AMB_AND:     return a & b;
            AMB_SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            AMB_SLTU:    return (a < b) ? 32'd1 : 32'd0;
            AMB_GECIR:   return b;
            AMB_SLL:     return a << sh;
            AMB_SRL:     return a >> sh;
            AMB_SRA:     return 32'($signed(a) >>> sh);
            AMB_MIN:     return ($signed(a) < $signed(b)) ? a : b;
            AMB_MAX:     return ($signed(a) < $signed(b)) ? b : a;
            AMB_MINU:    return (a < b) ? a : b;
            AMB_MAXU:    return (a < b) ? b : a;
            default:     return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        if (op == AMB_SLL || op == AMB_SRL || op == AMB_SRA)
            return (sh <= 4) ? 1 : (sh + 3) / 4;
        return 1;
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 19;
    vec_t tablo [NV];

    task automatic set_vec(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [31:0] exp, input int lat);
        tablo[i].op = op; tablo[i].a = a; tablo[i].b = b;
        tablo[i].tag = tag; tablo[i].exp = exp; tablo[i].lat = lat;
    endtask

    // Wait for gecerli_o on the 32-bit unit; reports cycles taken and cycles hazir_o was low.
    task automatic bekle_sonuc(input int sinir, output logic bitti, output int lat, output int dusuk);
        bitti = 1'b0; lat = 0; dusuk = 0;
        for (int c = 1; c <= sinir && !bitti; c++) begin
            @(negedge clk);
            if (gecerli_o) begin
                bitti = 1'b1;
                lat = c;
            end else if (!hazir_o) begin
                dusuk++;
            end
        end
    endtask

    task automatic sur(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        gecerli_i = 1'b1; kontrol_i = op; d1 = a; d2 = b; etiket_i = tag;
    endtask

    logic        bitti;
    int          lat, dusuk;
    logic        mv;
    logic [31:0] mval, pend;
    logic [4:0]  mtag, ptag;
    int          rem;
    logic        hz, serbest, nv, hic_gecerli;
    int          rlat;

    initial begin
        rst_n = 1'b0;
        gecerli_i = 0; hazir_i = 1; iptal_i = 0; kontrol_i = 0; d1 = 0; d2 = 0; etiket_i = 0;
        g64 = 0; hzi64 = 1; ip64 = 0; k64 = 0; a64 = 0; b64 = 0; t64 = 0;

        set_vec(0,  AMB_TOPLAMA, 32'hFFFFFFFF, 32'h1,        5'd7,  32'h00000000, 1);
        set_vec(1,  AMB_MIN,     32'h80000000, 32'h1,        5'd1,  32'h80000000, 1);
        set_vec(2,  AMB_MINU,    32'h80000000, 32'h1,        5'd2,  32'h00000001, 1);
        set_vec(3,  AMB_MAX,     32'h80000000, 32'h1,        5'd3,  32'h00000001, 1);
        set_vec(4,  AMB_MAXU,    32'h80000000, 32'h1,        5'd4,  32'h80000000, 1);
        set_vec(5,  AMB_CIKARMA, 32'd5,        32'd7,        5'd5,  32'hFFFFFFFE, 1);
        set_vec(6,  AMB_XOR,     32'hF0F0F0F0, 32'hFF00FF00, 5'd6,  32'h0FF00FF0, 1);
        set_vec(7,  AMB_OR,      32'h0000000F, 32'h000000F0, 5'd8,  32'h000000FF, 1);
        set_vec(8,  AMB_AND,     32'h0000FF00, 32'h00000FF0, 5'd9,  32'h00000F00, 1);
        set_vec(9,  AMB_SLT,     32'hFFFFFFFF, 32'h1,        5'd10, 32'h00000001, 1);
        set_vec(10, AMB_SLTU,    32'hFFFFFFFF, 32'h1,        5'd11, 32'h00000000, 1);
        set_vec(11, AMB_GECIR,   32'd123,      32'hDEADBEEF, 5'd12, 32'hDEADBEEF, 1);
        set_vec(12, 4'hF,        32'd1,        32'd2,        5'd13, 32'h00000000, 1);
        set_vec(13, AMB_SLL,     32'h12345678, 32'h0,        5'd14, 32'h12345678, 1);
        set_vec(14, AMB_SRA,     32'h80000000, 32'd31,       5'd15, 32'hFFFFFFFF, 8);
        set_vec(15, AMB_SRL,     32'h80000000, 32'd9,        5'd16, 32'h00400000, 3);
        set_vec(16, AMB_SLL,     32'h00000001, 32'd4,        5'd17, 32'h00000010, 1);
        set_vec(17, AMB_SRA,     32'hF0000000, 32'h25,       5'd18, 32'hFF800000, 2);
        set_vec(18, AMB_SLL,     32'h00000003, 32'h22,       5'd19, 32'h0000000C, 1);

        #12;
        kontrol("rst_gecerli", 64'(gecerli_o), 64'(1'b0));
        kontrol("rst_sonuc",   64'(sonuc_o),   64'd0);
        kontrol("rst_etiket",  64'(etiket_o),  64'd0);
        kontrol("rst_hazir",   64'(hazir_o),   64'(1'b1));
        kontrol("rst64_gecerli", 64'(go64), 64'(1'b0));
        kontrol("rst64_hazir",   64'(hzo64), 64'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single operations.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            hazir_i = 1'b1;
            sur(tablo[i].op, tablo[i].a, tablo[i].b, tablo[i].tag);
            #1 kontrol($sformatf("vec%0d_hazir", i), 64'(hazir_o), 64'(1'b1));
            @(posedge clk);
            #1 gecerli_i = 1'b0;
            bekle_sonuc(40, bitti, lat, dusuk);
            kontrol($sformatf("vec%0d_done", i),   64'(bitti),    64'(1'b1));
            kontrol($sformatf("vec%0d_sonuc", i),  64'(sonuc_o),  64'(tablo[i].exp));
            kontrol($sformatf("vec%0d_etiket", i), 64'(etiket_o), 64'(tablo[i].tag));
            kontrol($sformatf("vec%0d_lat", i),    64'(lat),      64'(tablo[i].lat));
            kontrol($sformatf("vec%0d_dusuk", i),  64'(dusuk),    64'(tablo[i].lat - 1));
        end

        // Held result, back-to-back shift accept, second result held, order preserved.
        @(negedge clk);
        hazir_i = 1'b0;
        sur(AMB_TOPLAMA, 32'd10, 32'd20, 5'd3);
        @(posedge clk);
        #1 gecerli_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            kontrol("tut1_gecerli", 64'(gecerli_o), 64'(1'b1));
            kontrol("tut1_sonuc",   64'(sonuc_o),   64'd30);
            kontrol("tut1_hazir",   64'(hazir_o),   64'(1'b0));
        end
        @(negedge clk);
        hazir_i = 1'b1;
        sur(AMB_SLL, 32'd1, 32'd9, 5'd4);
        #1 kontrol("b2b_hazir", 64'(hazir_o), 64'(1'b1));
        kontrol("b2b_etiket1", 64'(etiket_o), 64'd3);
        @(posedge clk);
        #1 gecerli_i = 1'b0; hazir_i = 1'b0;
        @(negedge clk);
        kontrol("b2b_bosalt", 64'(gecerli_o), 64'(1'b0));
        kontrol("b2b_mesgul", 64'(hazir_o),   64'(1'b0));
        bekle_sonuc(10, bitti, lat, dusuk);
        kontrol("tut2_done", 64'(bitti), 64'(1'b1));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            kontrol("tut2_sonuc",  64'(sonuc_o),  64'h200);
            kontrol("tut2_etiket", 64'(etiket_o), 64'd4);
            kontrol("tut2_gecerli", 64'(gecerli_o), 64'(1'b1));
        end
        hazir_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kontrol("tut2_tuketildi", 64'(gecerli_o), 64'(1'b0));

        // Flush mid-shift with a simultaneous new request.
        @(negedge clk);
        sur(AMB_SRA, 32'h80000000, 32'd31, 5'd9);
        @(posedge clk);
        #1 gecerli_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        kontrol("iptal_once_hazir", 64'(hazir_o), 64'(1'b0));
        sur(AMB_TOPLAMA, 32'd1, 32'd1, 5'd2);
        iptal_i = 1'b1;
        @(posedge clk);
        #1 iptal_i = 1'b0; gecerli_i = 1'b0;
        @(negedge clk);
        kontrol("iptal_gecerli", 64'(gecerli_o), 64'(1'b0));
        kontrol("iptal_hazir",   64'(hazir_o),   64'(1'b1));
        hic_gecerli = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gecerli_o) hic_gecerli = 1'b1;
        end
        kontrol("iptal_sonra_sessiz", 64'(hic_gecerli), 64'(1'b0));

        // 64-bit instance: long logical right shift.
        @(negedge clk);
        g64 = 1'b1; k64 = AMB_SRL; a64 = 64'hF000000000000000; b64 = 64'd60; t64 = 5'd5;
        @(posedge clk);
        #1 g64 = 1'b0;
        bitti = 1'b0; lat = 0;
        for (int c = 1; c <= 20 && !bitti; c++) begin
            @(negedge clk);
            if (go64) begin bitti = 1'b1; lat = c; end
        end
        kontrol("x64_done",   64'(bitti), 64'(1'b1));
        kontrol("x64_sonuc",  s64,        64'hF);
        kontrol("x64_etiket", 64'(eo64),  64'd5);
        kontrol("x64_lat",    64'(lat),   64'd4);

        // Asynchronous reset mid-shift.
        @(negedge clk);
        sur(AMB_TOPLAMA, 32'd5, 32'd6, 5'd1);
        @(posedge clk);
        #1 sur(AMB_SRA, 32'h80000000, 32'd31, 5'd2);
        @(posedge clk);
        #1 gecerli_i = 1'b0;
        @(negedge clk);
        kontrol("rstm_mesgul", 64'(hazir_o), 64'(1'b0));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        kontrol("rstm_gecerli", 64'(gecerli_o), 64'(1'b0));
        kontrol("rstm_sonuc",   64'(sonuc_o),   64'd0);
        kontrol("rstm_etiket",  64'(etiket_o),  64'd0);
        kontrol("rstm_hazir",   64'(hazir_o),   64'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Randomized traffic against the reference model.
        mv = 1'b0; mval = '0; mtag = '0; pend = '0; ptag = '0; rem = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            gecerli_i = ($urandom_range(0, 9) < 7);
            kontrol_i = 4'($urandom_range(0, 15));
            d1        = $urandom;
            d2        = $urandom;
            etiket_i  = 5'($urandom);
            hazir_i   = ($urandom_range(0, 3) != 0);
            iptal_i   = ($urandom_range(0, 49) == 0);
            #1;
            hz = (rem == 0) && (!mv || hazir_i);
            kontrol("rnd_hazir",   64'(hazir_o),   64'(hz));
            kontrol("rnd_gecerli", 64'(gecerli_o), 64'(mv));
            if (mv) begin
                kontrol("rnd_sonuc",  64'(sonuc_o),  64'(mval));
                kontrol("rnd_etiket", 64'(etiket_o), 64'(mtag));
            end
            @(posedge clk);
            serbest = !mv || hazir_i;
            if (iptal_i) begin
                mv = 1'b0;
                rem = 0;
            end else begin
                nv = mv && !hazir_i;
                if (rem > 0) begin
                    if (rem == 1) begin
                        if (serbest) begin
                            nv = 1'b1; mval = pend; mtag = ptag; rem = 0;
                        end
                    end else begin
                        rem--;
                    end
                end else if (gecerli_i && hz) begin
                    rlat = ref_lat(kontrol_i, d2);
                    if (rlat == 1) begin
                        nv = 1'b1; mval = ref_alu(kontrol_i, d1, d2); mtag = etiket_i;
                    end else begin
                        rem = rlat - 1; pend = ref_alu(kontrol_i, d1, d2); ptag = etiket_i;
                    end
                end
                mv = nv;
            end
        end

        @(negedge clk);
        gecerli_i = 1'b0; iptal_i = 1'b0; hazir_i = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
